// File: rtl/vram_arbiter_if.sv
// VRAM arbiter bus: spectrum writer, display scan and frame-buffer SRAM.
// master drives writer/display/SRAM-read side, slave is the arbiter.
interface vram_arbiter_if #(
  parameter int bw_addr  = 17,
  parameter int bw_color = 15
);
  logic [8:0]          X;
  logic [6:0]          Y;
  logic [bw_color-1:0] Color;
  logic                Screen;
  logic                SWBusy;
  logic                SWClockEn;
  logic                StartLoader;
  logic                VSync;
  logic                DispReq;
  logic [8:0]          DispX;
  logic [6:0]          DispY;
  logic [bw_color-1:0] DispQ;
  logic                DispValid;
  logic                DispScreen;
  logic                DispOverrun;
  logic [bw_addr-1:0]  SRAM_Addr;
  logic [bw_color:0]   SRAM_D;
  logic [bw_color:0]   SRAM_Q;
  logic                SRAM_Doe;
  logic                SRAM_nWE;
  logic                SRAM_nOE;

  modport master (
    output X, Y, Color, Screen, SWBusy,
    output VSync, DispReq, DispX, DispY,
    output SRAM_Q,
    input  SWClockEn, StartLoader,
    input  DispQ, DispValid, DispScreen, DispOverrun,
    input  SRAM_Addr, SRAM_D, SRAM_Doe, SRAM_nWE, SRAM_nOE
  );

  modport slave (
    input  X, Y, Color, Screen, SWBusy,
    input  VSync, DispReq, DispX, DispY,
    input  SRAM_Q,
    output SWClockEn, StartLoader,
    output DispQ, DispValid, DispScreen, DispOverrun,
    output SRAM_Addr, SRAM_D, SRAM_Doe, SRAM_nWE, SRAM_nOE
  );
endinterface

// File: rtl/vram_arbiter.sv
// Double-buffered frame-buffer SRAM arbiter; display reads beat writer.
// Define VRAM_WRITE_FIFO_EN for a 4-entry writer FIFO.
module vram_arbiter #(
  parameter int bw_addr  = 17,
  parameter int bw_color = 15
) (
  input logic           Clock,
  input logic           Reset,
  vram_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, RD1, RD2, WR1, WR2
  } state_t;

  typedef struct packed {
    logic                scr;
    logic [6:0]          y;
    logic [8:0]          x;
    logic [bw_color-1:0] col;
  } pix_t;

  state_t state, state_nx;

  logic               pend;
  logic [bw_addr-1:0] pend_addr;
  logic               rd_req;
  logic [bw_addr-1:0] rd_addr;
  logic               ovr;
  logic [bw_color-1:0] q_r;
  logic               valid_r;

  logic disp_scr;
  logic vs_q;
  logic vs_edge;
  logic edge_q;
  logic sl_r;

  pix_t pix_in;
  pix_t wr_src;
  logic wr_avail;

  logic [bw_addr-1:0] addr_q, addr_d;
  logic [bw_color:0]  d_q, d_d;
  logic               doe_q, doe_d;
  logic               nwe_q, nwe_d;
  logic               noe_q, noe_d;

  logic unused_q_msb;
  assign unused_q_msb = bus.SRAM_Q[bw_color];

  assign pix_in = {bus.Screen, bus.Y, bus.X, bus.Color};

  // A pending slot outranks a fresh request; both use the screen at request time
  assign rd_req  = pend | bus.DispReq;
  assign rd_addr = pend ? pend_addr
                        : {disp_scr, bus.DispY, bus.DispX};

`ifdef VRAM_WRITE_FIFO_EN
  pix_t       fifo [4];
  logic [2:0] wp, rp;
  logic       full, empty;
  logic       push, pop;

  assign full  = (wp[2] != rp[2]) && (wp[1:0] == rp[1:0]);
  assign empty = (wp == rp);
  assign bus.SWClockEn = ~full & ~Reset;
  assign push  = bus.SWClockEn & bus.SWBusy;
  assign pop   = (state_nx == WR1);

  assign wr_avail = ~empty;
  assign wr_src   = fifo[rp[1:0]];

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + 3'd1;
      if (pop)  rp <= rp + 3'd1;
    end
  end

  always_ff @(posedge Clock) begin
    if (push) fifo[wp[1:0]] <= pix_in;
  end
`else
  // Accepted pixel goes straight into the SRAM output registers
  assign bus.SWClockEn = ~Reset & ~rd_req &
                         (state == IDLE || state == WR2);
  assign wr_avail = bus.SWClockEn & bus.SWBusy;
  assign wr_src   = pix_in;
`endif

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, WR2: begin
        if (rd_req)        state_nx = RD1;
        else if (wr_avail) state_nx = WR1;
        else               state_nx = IDLE;
      end
      RD1:     state_nx = RD2;
      RD2:     state_nx = IDLE;
      WR1:     state_nx = WR2;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    addr_d = addr_q;
    d_d    = d_q;
    doe_d  = 1'b0;
    nwe_d  = 1'b1;
    noe_d  = 1'b1;
    unique case (state_nx)
      RD1: begin
        addr_d = rd_addr;
        noe_d  = 1'b0;
      end
      RD2: noe_d = 1'b0;
      WR1: begin
        addr_d = {wr_src.scr, wr_src.y, wr_src.x};
        d_d    = {1'b0, wr_src.col};
        doe_d  = 1'b1;
        nwe_d  = 1'b0;
      end
      WR2:     doe_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      addr_q <= '0;
      d_q    <= '0;
      doe_q  <= 1'b0;
      nwe_q  <= 1'b1;
      noe_q  <= 1'b1;
    end else begin
      addr_q <= addr_d;
      d_q    <= d_d;
      doe_q  <= doe_d;
      nwe_q  <= nwe_d;
      noe_q  <= noe_d;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      pend      <= 1'b0;
      pend_addr <= '0;
      ovr       <= 1'b0;
      q_r       <= '0;
      valid_r   <= 1'b0;
    end else begin
      valid_r <= (state == RD2);
      if (state == RD2) begin
        q_r  <= bus.SRAM_Q[bw_color-1:0];
        pend <= 1'b0;
      end
      if (bus.DispReq) begin
        if (pend) begin
          ovr <= 1'b1;
        end else begin
          pend      <= 1'b1;
          pend_addr <= {disp_scr, bus.DispY, bus.DispX};
        end
      end
    end
  end

  assign vs_edge = bus.VSync & ~vs_q;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      vs_q     <= 1'b0;
      edge_q   <= 1'b0;
      sl_r     <= 1'b0;
      disp_scr <= 1'b0;
    end else begin
      vs_q   <= bus.VSync;
      edge_q <= vs_edge;
      sl_r   <= edge_q;
      if (vs_edge) disp_scr <= ~bus.Screen;
    end
  end

  assign bus.StartLoader = sl_r;
  assign bus.DispQ       = q_r;
  assign bus.DispValid   = valid_r;
  assign bus.DispScreen  = disp_scr;
  assign bus.DispOverrun = ovr;
  assign bus.SRAM_Addr   = addr_q;
  assign bus.SRAM_D      = d_q;
  assign bus.SRAM_Doe    = doe_q;
  assign bus.SRAM_nWE    = nwe_q;
  assign bus.SRAM_nOE    = noe_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: reset, reads, writes, overrun, swap.
// Expected values are hand-computed from the block's behaviour.
module tb_vram_arbiter;

  logic Clock = 1'b0;
  logic Reset;
  always #5 Clock = ~Clock;

  vram_arbiter_if bus ();

  vram_arbiter dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge Clock) cyc <= cyc + 1;

  logic [16:0] wa [$];
  logic [15:0] wd [$];
  int          wc [$];
  logic [16:0] ra [$];
  int          vc [$];
  logic [14:0] vq [$];
  int          sl_cnt = 0;
  int          en_rd  = 0;

  always @(negedge Clock) begin
    if (Reset === 1'b0) begin
      if (bus.SRAM_nWE === 1'b0) begin
        wa.push_back(bus.SRAM_Addr);
        wd.push_back(bus.SRAM_D);
        wc.push_back(cyc);
      end
      if (bus.SRAM_nOE === 1'b0) begin
        ra.push_back(bus.SRAM_Addr);
        if (bus.SWClockEn === 1'b1) en_rd++;
      end
      if (bus.DispValid === 1'b1) begin
        vc.push_back(cyc);
        vq.push_back(bus.DispQ);
      end
      if (bus.StartLoader === 1'b1) sl_cnt++;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge Clock);
  endtask

  task automatic clear_logs();
    wa.delete(); wd.delete(); wc.delete();
    ra.delete(); vc.delete(); vq.delete();
    en_rd = 0;
  endtask

  task automatic stream(input int n, input logic scr,
                        input logic [6:0] y,
                        input logic [14:0] col);
    int i = 0;
    int guard = 0;
    while (i < n && guard < 200) begin
      @(negedge Clock);
      bus.SWBusy = 1'b1;
      bus.X      = i[8:0];
      bus.Y      = y;
      bus.Screen = scr;
      bus.Color  = col;
      #4;
      if (bus.SWClockEn === 1'b1) i++;
      guard++;
    end
    @(negedge Clock);
    bus.SWBusy = 1'b0;
    check("stream_accepts", i, n);
  endtask

  int treq;

  initial begin
    Reset       = 1'b1;
    bus.X       = '0;
    bus.Y       = '0;
    bus.Color   = '0;
    bus.Screen  = 1'b0;
    bus.SWBusy  = 1'b0;
    bus.VSync   = 1'b0;
    bus.DispReq = 1'b0;
    bus.DispX   = '0;
    bus.DispY   = '0;
    bus.SRAM_Q  = '0;

    #1;
    check("rst_nwe",  bus.SRAM_nWE, 1);
    check("rst_noe",  bus.SRAM_nOE, 1);
    check("rst_doe",  bus.SRAM_Doe, 0);
    check("rst_addr", bus.SRAM_Addr, 0);
    check("rst_d",    bus.SRAM_D, 0);
    check("rst_swce", bus.SWClockEn, 0);
    check("rst_sl",   bus.StartLoader, 0);
    check("rst_vld",  bus.DispValid, 0);
    check("rst_q",    bus.DispQ, 0);
    check("rst_scr",  bus.DispScreen, 0);
    check("rst_ovr",  bus.DispOverrun, 0);

    idle(2);
    Reset = 1'b0;
    idle(2);

    // Single read from IDLE
    clear_logs();
    bus.SRAM_Q  = 16'h7FFF;
    bus.DispX   = 9'd5;
    bus.DispY   = 7'd3;
    bus.DispReq = 1'b1;
    @(negedge Clock);
    bus.DispReq = 1'b0;
    check("rd_addr_t1", bus.SRAM_Addr, 17'h00605);
    check("rd_noe_t1",  bus.SRAM_nOE, 0);
    @(negedge Clock);
    check("rd_vld_t2",  bus.DispValid, 0);
    @(negedge Clock);
    check("rd_vld_t3",  bus.DispValid, 1);
    check("rd_q_t3",    bus.DispQ, 15'h7FFF);
    @(negedge Clock);
    check("rd_vld_t4",  bus.DispValid, 0);
    check("rd_ovr",     bus.DispOverrun, 0);
    idle(3);

    // Eight-pixel stream into screen 1
    clear_logs();
    stream(8, 1'b1, 7'd10, 15'h1234);
    idle(20);
    check("wr_count", wa.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < wa.size()) begin
        check("wr_addr", wa[i], 17'h11400 + i);
        check("wr_data", wd[i], 16'h1234);
      end
    end
    if (wc.size() == 8) check("wr_span", wc[7] - wc[0], 14);

    // Same stream, read lands in WR1 of pixel 2
    clear_logs();
    bus.SRAM_Q = 16'h8ABC;
    treq = 0;
    fork
      stream(8, 1'b1, 7'd10, 15'h1234);
      begin
        int g = 0;
        do begin
          @(negedge Clock);
          g++;
        end while (!(bus.SRAM_nWE === 1'b0 &&
                     bus.SRAM_Addr === 17'h11402) && g < 100);
        check("req_hit_wr1", g < 100, 1);
        bus.DispX   = 9'd9;
        bus.DispY   = 7'd2;
        bus.DispReq = 1'b1;
        treq = cyc;
        @(negedge Clock);
        bus.DispReq = 1'b0;
      end
    join
    idle(20);
    check("mix_wr_count", wa.size(), 8);
    check("mix_vld_count", vc.size(), 1);
    if (vc.size() > 0) begin
      check("mix_vld_lat", vc[0] - treq, 4);
      check("mix_q", vq[0], 15'h0ABC);
    end
    if (ra.size() > 0) check("mix_rd_addr", ra[0], 17'h00409);
    if (wc.size() == 8) check("mix_wr_span", wc[7] - wc[0], 17);
`ifndef VRAM_WRITE_FIFO_EN
    check("mix_swce_rd", en_rd, 0);
`endif

    // Back-to-back requests overrun
    clear_logs();
    bus.SRAM_Q  = 16'h0155;
    bus.DispX   = 9'd7;
    bus.DispY   = 7'd1;
    bus.DispReq = 1'b1;
    @(negedge Clock);
    bus.DispReq = 1'b0;
    @(negedge Clock);
    check("ovr_before", bus.DispOverrun, 0);
    bus.DispReq = 1'b1;
    @(negedge Clock);
    bus.DispReq = 1'b0;
    idle(10);
    check("ovr_vld_count", vc.size(), 1);
    check("ovr_set", bus.DispOverrun, 1);
    idle(10);
    check("ovr_sticky", bus.DispOverrun, 1);

    // Frame swap
    check("sl_none", sl_cnt, 0);
    bus.Screen = 1'b0;
    bus.VSync  = 1'b1;
    @(negedge Clock);
    check("swap_scr", bus.DispScreen, 1);
    check("swap_sl0", bus.StartLoader, 0);
    @(negedge Clock);
    check("swap_sl1", bus.StartLoader, 1);
    @(negedge Clock);
    check("swap_sl2", bus.StartLoader, 0);
    idle(5);
    bus.VSync = 1'b0;
    idle(5);
    check("swap_sl_cnt", sl_cnt, 1);
    check("swap_scr_hold", bus.DispScreen, 1);

    // Reset during WR1
    bus.X      = 9'd3;
    bus.Y      = 7'd5;
    bus.Screen = 1'b0;
    bus.SWBusy = 1'b1;
    @(negedge Clock);
    bus.SWBusy = 1'b0;
    begin
      int g = 0;
      while (bus.SRAM_nWE !== 1'b0 && g < 5) begin
        @(negedge Clock);
        g++;
      end
      check("rstw_wr1", bus.SRAM_nWE, 0);
    end
    #2;
    Reset = 1'b1;
    #1;
    check("rstw_nwe",  bus.SRAM_nWE, 1);
    check("rstw_doe",  bus.SRAM_Doe, 0);
    check("rstw_addr", bus.SRAM_Addr, 0);
    check("rstw_d",    bus.SRAM_D, 0);
    check("rstw_swce", bus.SWClockEn, 0);
    check("rstw_scr",  bus.DispScreen, 0);
    check("rstw_ovr",  bus.DispOverrun, 0);
    check("rstw_q",    bus.DispQ, 0);
    @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);
    bus.DispX   = 9'd1;
    bus.DispY   = 7'd0;
    bus.DispReq = 1'b1;
    @(negedge Clock);
    bus.DispReq = 1'b0;
    check("rstw_idle_rd1", bus.SRAM_nOE, 0);
    check("rstw_idle_addr", bus.SRAM_Addr, 17'h00001);
    idle(5);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
